// File: rtl/lights_pkg.sv
// Shared definitions for the lights command controller: command characters,
// acknowledgement bytes, source-select encoding and controller state encoding.
package lights_pkg;

    localparam int unsigned BYTE_W = 8;

    // Command characters received from the UART
    localparam logic [BYTE_W-1:0] CMD_AUTO   = 8'h61; // 'a'
    localparam logic [BYTE_W-1:0] CMD_RAND   = 8'h72; // 'r'
    localparam logic [BYTE_W-1:0] CMD_STORED = 8'h73; // 's'
    localparam logic [BYTE_W-1:0] CMD_USER   = 8'h69; // 'i'
    localparam logic [BYTE_W-1:0] CMD_UPDATE = 8'h75; // 'u'
    localparam logic [BYTE_W-1:0] CMD_PUT    = 8'h70; // 'p'
    localparam logic [BYTE_W-1:0] CMD_WRITE  = 8'h77; // 'w'

    // Acknowledgement bytes sent back to the UART
    localparam logic [BYTE_W-1:0] ACK_OK  = 8'h21; // '!'
    localparam logic [BYTE_W-1:0] ACK_ERR = 8'h3F; // '?'

    typedef enum logic [1:0] {
        SRC_AUTO   = 2'd0,
        SRC_RANDOM = 2'd1,
        SRC_STORED = 2'd2,
        SRC_USER   = 2'd3
    } src_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WADDR = 2'd2
    } state_e;

endpackage

// File: rtl/lights_cmd_ctrl_if.sv
// Bus between the command controller and its surroundings.
//   rx_valid/rx_byte : received UART bytes      tick     : timebase pulse
//   tx_busy/tx_start/tx_byte : ack transmitter   src_sel  : intensity source
//   user_int : user intensities                  ram_*    : pattern RAM write
//   err : timeout / unknown-command pulse
// master drives the inputs of the controller, slave is the controller.
interface lights_cmd_ctrl_if #(
    parameter int unsigned DATA_W = 72,
    parameter int unsigned ADDR_W = 8
);
    import lights_pkg::*;

    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              tick;
    logic              tx_busy;
    logic              tx_start;
    logic [7:0]        tx_byte;
    src_sel_e          src_sel;
    logic [DATA_W-1:0] user_int;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              err;

    modport master (
        output rx_valid, rx_byte, tick, tx_busy,
        input  tx_start, tx_byte, src_sel, user_int, ram_we, ram_addr, ram_din, err
    );

    modport slave (
        input  rx_valid, rx_byte, tick, tx_busy,
        output tx_start, tx_byte, src_sel, user_int, ram_we, ram_addr, ram_din, err
    );

endinterface

// File: rtl/cmd_timeout.sv
// Tick counter that abandons an open command after TIMEOUT_TICKS idle ticks.
//   clk, rst   : clock, synchronous active-high reset
//   i_en       : counting allowed (controller not idle); held at 0 otherwise
//   i_clr      : clear (a byte arrived); wins over a coincident tick
//   i_tick     : timebase pulse
//   o_expire_c : combinational one-cycle pulse when the limit is reached
module cmd_timeout #(
    parameter int unsigned TIMEOUT_TICKS = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    input  logic i_tick,
    output logic o_expire_c
);
    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] r_cnt;

    // Expiry is the tick that would bring the count to the limit
    assign o_expire_c = i_en && !i_clr && i_tick &&
                        (r_cnt == CNT_W'(TIMEOUT_TICKS - 1));

    always_ff @(posedge clk) begin
        if (rst || !i_en || i_clr || o_expire_c) begin
            r_cnt <= '0;
        end else if (i_tick) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/lights_cmd_ctrl.sv
// Command controller: parses UART bytes into source selection, user-intensity
// loads, pattern RAM writes and acknowledgement bytes.
//   clk, rst : clock, synchronous active-high reset
//   bus      : lights_cmd_ctrl_if slave (rx bytes, tick, tx ack, outputs)
module lights_cmd_ctrl
    import lights_pkg::*;
#(
    parameter int unsigned DATA_W        = 72,
    parameter int unsigned ADDR_W        = 8,
    parameter int unsigned TIMEOUT_TICKS = 64
) (
    input  logic             clk,
    input  logic             rst,
    lights_cmd_ctrl_if.slave bus
);
    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(NBYTES + 1);

    state_e              r_state,       w_state_nxt;
    src_sel_e            r_src_sel,     w_src_sel_nxt;
    logic [DATA_W-1:0]   r_user_int,    w_user_int_nxt;
    logic [DATA_W-1:0]   r_shadow,      w_shadow_nxt;
    logic [DATA_W-1:0]   r_shift,       w_shift_nxt;
    logic [CNT_W-1:0]    r_byte_cnt,    w_byte_cnt_nxt;
    logic                r_ram_we,      w_ram_we_nxt;
    logic [ADDR_W-1:0]   r_ram_addr,    w_ram_addr_nxt;
    logic [DATA_W-1:0]   r_ram_din,     w_ram_din_nxt;
    logic                r_err,         w_err_nxt;
    logic                r_tx_start,    w_tx_start_nxt;
    logic [7:0]          r_tx_byte,     w_tx_byte_nxt;
    logic                r_ack_pending, w_ack_pending_nxt;
    logic                w_ack;
    logic [7:0]          w_ack_byte;
    logic                w_expire;
    logic                w_timer_en;

    assign w_timer_en = (r_state != ST_IDLE);

    cmd_timeout #(.TIMEOUT_TICKS(TIMEOUT_TICKS)) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_timer_en),
        .i_clr      (bus.rx_valid),
        .i_tick     (bus.tick),
        .o_expire_c (w_expire)
    );

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_src_sel     <= SRC_AUTO;
            r_user_int    <= '0;
            r_shadow      <= '0;
            r_shift       <= '0;
            r_byte_cnt    <= '0;
            r_ram_we      <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_din     <= '0;
            r_err         <= 1'b0;
            r_tx_start    <= 1'b0;
            r_tx_byte     <= '0;
            r_ack_pending <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_src_sel     <= w_src_sel_nxt;
            r_user_int    <= w_user_int_nxt;
            r_shadow      <= w_shadow_nxt;
            r_shift       <= w_shift_nxt;
            r_byte_cnt    <= w_byte_cnt_nxt;
            r_ram_we      <= w_ram_we_nxt;
            r_ram_addr    <= w_ram_addr_nxt;
            r_ram_din     <= w_ram_din_nxt;
            r_err         <= w_err_nxt;
            r_tx_start    <= w_tx_start_nxt;
            r_tx_byte     <= w_tx_byte_nxt;
            r_ack_pending <= w_ack_pending_nxt;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_state_nxt       = r_state;
        w_src_sel_nxt     = r_src_sel;
        w_user_int_nxt    = r_user_int;
        w_shadow_nxt      = r_shadow;
        w_shift_nxt       = r_shift;
        w_byte_cnt_nxt    = r_byte_cnt;
        w_ram_we_nxt      = 1'b0;
        w_ram_addr_nxt    = r_ram_addr;
        w_ram_din_nxt     = r_ram_din;
        w_err_nxt         = 1'b0;
        w_tx_start_nxt    = 1'b0;
        w_tx_byte_nxt     = r_tx_byte;
        w_ack_pending_nxt = r_ack_pending;
        w_ack             = 1'b0;
        w_ack_byte        = ACK_OK;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    w_ack = 1'b1;
                    case (bus.rx_byte)
                        CMD_AUTO:   w_src_sel_nxt  = SRC_AUTO;
                        CMD_RAND:   w_src_sel_nxt  = SRC_RANDOM;
                        CMD_STORED: w_src_sel_nxt  = SRC_STORED;
                        CMD_USER:   w_src_sel_nxt  = SRC_USER;
                        CMD_UPDATE: w_user_int_nxt = r_shadow;
                        CMD_PUT: begin
                            w_ack          = 1'b0;
                            w_byte_cnt_nxt = '0;
                            w_state_nxt    = ST_LOAD;
                        end
                        CMD_WRITE: begin
                            w_ack       = 1'b0;
                            w_state_nxt = ST_WADDR;
                        end
                        default: begin
                            w_err_nxt  = 1'b1;
                            w_ack_byte = ACK_ERR;
                        end
                    endcase
                end
            end
            ST_LOAD: begin
                if (bus.rx_valid) begin
                    w_shift_nxt = {r_shift[DATA_W-9:0], bus.rx_byte};
                    if (r_byte_cnt == CNT_W'(NBYTES - 1)) begin
                        // Shadow only changes on a complete load
                        w_shadow_nxt = w_shift_nxt;
                        w_state_nxt  = ST_IDLE;
                        w_ack        = 1'b1;
                    end else begin
                        w_byte_cnt_nxt = r_byte_cnt + CNT_W'(1);
                    end
                end else if (w_expire) begin
                    w_state_nxt = ST_IDLE;
                    w_err_nxt   = 1'b1;
                    w_ack       = 1'b1;
                    w_ack_byte  = ACK_ERR;
                end
            end
            ST_WADDR: begin
                if (bus.rx_valid) begin
                    w_ram_we_nxt   = 1'b1;
                    w_ram_addr_nxt = ADDR_W'(bus.rx_byte);
                    w_ram_din_nxt  = r_shadow;
                    w_state_nxt    = ST_IDLE;
                    w_ack          = 1'b1;
                end else if (w_expire) begin
                    w_state_nxt = ST_IDLE;
                    w_err_nxt   = 1'b1;
                    w_ack       = 1'b1;
                    w_ack_byte  = ACK_ERR;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // A fresh ack replaces any pending one and defers launch by a cycle
        if (w_ack) begin
            w_tx_byte_nxt     = w_ack_byte;
            w_ack_pending_nxt = 1'b1;
        end else if (r_ack_pending && !bus.tx_busy) begin
            w_tx_start_nxt    = 1'b1;
            w_ack_pending_nxt = 1'b0;
        end
    end

    assign bus.tx_start = r_tx_start;
    assign bus.tx_byte  = r_tx_byte;
    assign bus.src_sel  = r_src_sel;
    assign bus.user_int = r_user_int;
    assign bus.ram_we   = r_ram_we;
    assign bus.ram_addr = r_ram_addr;
    assign bus.ram_din  = r_ram_din;
    assign bus.err      = r_err;

endmodule

// File: tb/tb_lights_cmd_ctrl.sv
// Directed bench for lights_cmd_ctrl with ack/RAM-write scoreboards.
module tb_lights_cmd_ctrl;
    import lights_pkg::*;

    localparam int unsigned DATA_W = 72;
    localparam int unsigned ADDR_W = 8;
    localparam logic [DATA_W-1:0] LOAD_VAL = 72'h010203040506070809;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lights_cmd_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    lights_cmd_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_TICKS(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int errors   = 0;
    int tx_cnt   = 0;
    int ram_cnt  = 0;
    int err_seen = 0;
    int err_exp  = 0;
    int prior;

    logic [7:0]        tx_q[$];
    logic [7:0]        addr_q[$];
    logic [DATA_W-1:0] din_q[$];

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitors: acks and RAM writes popped from the scoreboards
    always @(negedge clk) begin
        if (bus.tx_start === 1'b1) begin
            tx_cnt++;
            check("tx_expected", DATA_W'(tx_q.size() != 0), DATA_W'(1));
            if (tx_q.size() != 0) check("tx_byte", DATA_W'(bus.tx_byte), DATA_W'(tx_q.pop_front()));
        end
        if (bus.ram_we === 1'b1) begin
            ram_cnt++;
            check("ram_expected", DATA_W'(addr_q.size() != 0), DATA_W'(1));
            if (addr_q.size() != 0) begin
                check("ram_addr", DATA_W'(bus.ram_addr), DATA_W'(addr_q.pop_front()));
                check("ram_din", bus.ram_din, din_q.pop_front());
            end
        end
        if (bus.err === 1'b1) err_seen++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_tick(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.tick = 1'b1;
            @(negedge clk);
            bus.tick = 1'b0;
        end
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_byte  = '0;
        bus.tick     = 1'b0;
        bus.tx_busy  = 1'b0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_src_sel",  DATA_W'(bus.src_sel),  DATA_W'(0));
        check("rst_user_int", bus.user_int,          DATA_W'(0));
        check("rst_tx_start", DATA_W'(bus.tx_start), DATA_W'(0));
        check("rst_tx_byte",  DATA_W'(bus.tx_byte),  DATA_W'(0));
        check("rst_ram_we",   DATA_W'(bus.ram_we),   DATA_W'(0));
        check("rst_err",      DATA_W'(bus.err),      DATA_W'(0));

        // 'r' selects RANDOM at N+1, ack launches at N+2
        tx_q.push_back(ACK_OK);
        send(CMD_RAND);
        check("r_src_sel",     DATA_W'(bus.src_sel),  DATA_W'(1));
        check("r_err",         DATA_W'(bus.err),      DATA_W'(0));
        check("r_no_early_tx", DATA_W'(bus.tx_start), DATA_W'(0));
        idle(1);
        check("r_tx_start_n2", DATA_W'(bus.tx_start), DATA_W'(1));
        idle(4);

        // 'p' plus nine back-to-back bytes, then 'u'
        tx_q.push_back(ACK_OK);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = CMD_PUT;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            bus.rx_byte = 8'(i);
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        check("load_user_untouched", bus.user_int, DATA_W'(0));
        idle(4);
        tx_q.push_back(ACK_OK);
        send(CMD_UPDATE);
        check("u_user_int", bus.user_int, LOAD_VAL);
        idle(4);

        // 'w' 0x7F writes the shadow for exactly one cycle
        send(CMD_WRITE);
        check("w_no_we_yet", DATA_W'(bus.ram_we), DATA_W'(0));
        tx_q.push_back(ACK_OK);
        addr_q.push_back(8'h7F);
        din_q.push_back(LOAD_VAL);
        send(8'h7F);
        check("w_ram_we",   DATA_W'(bus.ram_we),   DATA_W'(1));
        check("w_ram_addr", DATA_W'(bus.ram_addr), DATA_W'(8'h7F));
        check("w_ram_din",  bus.ram_din,           LOAD_VAL);
        idle(1);
        check("w_we_single", DATA_W'(bus.ram_we), DATA_W'(0));
        idle(4);

        // Partial load abandoned after 64 idle ticks
        send(CMD_PUT);
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        pulse_tick(63);
        check("to_not_yet", DATA_W'(bus.err), DATA_W'(0));
        tx_q.push_back(ACK_ERR);
        err_exp++;
        pulse_tick(1);
        check("to_err", DATA_W'(bus.err), DATA_W'(1));
        idle(1);
        check("to_err_pulse", DATA_W'(bus.err), DATA_W'(0));
        idle(4);
        tx_q.push_back(ACK_OK);
        send(CMD_UPDATE);
        check("to_user_kept", bus.user_int, LOAD_VAL);
        idle(4);
        tx_q.push_back(ACK_OK);
        send(CMD_USER);
        check("to_idle_cmd", DATA_W'(bus.src_sel), DATA_W'(3));
        idle(4);

        // Byte arriving with the limit-reaching tick wins over the timeout
        send(CMD_WRITE);
        pulse_tick(63);
        tx_q.push_back(ACK_OK);
        addr_q.push_back(8'h05);
        din_q.push_back(LOAD_VAL);
        @(negedge clk);
        bus.tick     = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_byte  = 8'h05;
        @(negedge clk);
        bus.tick     = 1'b0;
        bus.rx_valid = 1'b0;
        check("tk_ram_we",   DATA_W'(bus.ram_we),   DATA_W'(1));
        check("tk_ram_addr", DATA_W'(bus.ram_addr), DATA_W'(8'h05));
        check("tk_no_err",   DATA_W'(bus.err),      DATA_W'(0));
        idle(4);

        // Unknown byte while transmitter busy
        bus.tx_busy = 1'b1;
        prior = tx_cnt;
        tx_q.push_back(ACK_ERR);
        err_exp++;
        send(8'h78);
        check("x_err",     DATA_W'(bus.err),     DATA_W'(1));
        check("x_src_sel", DATA_W'(bus.src_sel), DATA_W'(3));
        idle(100);
        check("x_no_tx_busy", DATA_W'(tx_cnt), DATA_W'(prior));
        bus.tx_busy = 1'b0;
        idle(4);
        check("x_one_tx", DATA_W'(tx_cnt), DATA_W'(prior + 1));

        // Second ack while one is pending replaces it
        bus.tx_busy = 1'b1;
        prior = tx_cnt;
        tx_q.push_back(ACK_ERR);
        err_exp++;
        send(CMD_STORED);
        send(8'h7A);
        check("lw_src_sel", DATA_W'(bus.src_sel), DATA_W'(2));
        idle(10);
        bus.tx_busy = 1'b0;
        idle(4);
        check("lw_one_tx", DATA_W'(tx_cnt), DATA_W'(prior + 1));

        // Reset between 'w' and its address byte
        send(CMD_WRITE);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rw_src_sel", DATA_W'(bus.src_sel), DATA_W'(0));
        check("rw_tx_byte", DATA_W'(bus.tx_byte), DATA_W'(0));
        check("rw_ram_we",  DATA_W'(bus.ram_we),  DATA_W'(0));
        prior = ram_cnt;
        tx_q.push_back(ACK_ERR);
        err_exp++;
        send(8'h7F);
        check("rw_cmd_err", DATA_W'(bus.err),    DATA_W'(1));
        check("rw_no_we",   DATA_W'(bus.ram_we), DATA_W'(0));
        idle(4);
        check("rw_ram_cnt", DATA_W'(ram_cnt), DATA_W'(prior));

        // Scoreboards drained, event totals match
        idle(4);
        check("end_tx_q",  DATA_W'(tx_q.size()),   DATA_W'(0));
        check("end_ram_q", DATA_W'(addr_q.size()), DATA_W'(0));
        check("end_err",   DATA_W'(err_seen),      DATA_W'(err_exp));
        check("end_ram",   DATA_W'(ram_cnt),       DATA_W'(2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lights_cmd_ctrl.md
# lights_cmd_ctrl

Command controller for the lights top level. It parses the byte stream from the UART receiver and sequences four things: the LED-intensity source selection, the user-intensity register, writes into the pattern RAM, and acknowledgement bytes to the UART transmitter. It replaces the ad hoc command decoding in the top level. It adds three properties that decoding lacked: a defined reset state, atomic 72-bit loads, and a timeout that abandons half-received multi-byte commands.

## Interface
Parameters:
- DATA_W, 72, intensity word width (24 LEDs × 3 bits); must be a multiple of 8
- ADDR_W, 8, pattern RAM address width
- TIMEOUT_TICKS, 64, `tick` pulses without a byte before an open command is abandoned; range 1..255

Ports:
- clk  in  1  single design clock
- rst  in  1  synchronous, active-high reset
- rx_valid  in  1  one-cycle pulse per received byte (edge-detected upstream)
- rx_byte  in  8  received byte, valid when rx_valid=1
- tick  in  1  one-cycle timebase pulse from the tick generator
- tx_busy  in  1  UART transmitter busy
- tx_start  out  1  one-cycle pulse: send tx_byte
- tx_byte  out  8  acknowledgement byte
- src_sel  out  2  source select: 0 AUTO, 1 RANDOM, 2 STORED, 3 USER
- user_int  out  DATA_W  user-defined intensities
- ram_we  out  1  pattern RAM write strobe
- ram_addr  out  ADDR_W  pattern RAM address, valid with ram_we
- ram_din  out  DATA_W  pattern RAM write data, valid with ram_we
- err  out  1  one-cycle pulse on timeout or unknown command

## Operation
- Reset values:
  - src_sel=0 (AUTO); user_int=0; shadow=0; shift=0
  - ram_we=0; tx_start=0; tx_byte=0; err=0
  - state=IDLE; ack_pending=0; timeout counter=0
- State machine: IDLE, LOAD, WADDR.
- IDLE, on rx_valid:
  - 'a' → src_sel=0; 'r' → 1; 's' → 2; 'i' → 3; each acks '!'
  - 'u' → user_int←shadow; ack '!'
  - 'p' → LOAD with byte count=0
  - 'w' → WADDR
  - any other byte → err pulse, ack '?'; src_sel unchanged
- LOAD: each rx_valid shifts the byte into `shift`, MSB-first: shift←{shift[DATA_W-9:0], byte}. On byte DATA_W/8 (the 9th by default): shadow←final shift value, go to IDLE, ack '!'. Any byte value is accepted, including command characters.
- WADDR: on rx_valid, pulse ram_we with ram_addr=byte and ram_din=shadow, go to IDLE, ack '!'.
- Timeout, in LOAD or WADDR:
  - counter clears on every rx_valid and on entry to the state
  - counter increments on each tick
  - when it reaches TIMEOUT_TICKS: go to IDLE, err pulse, ack '?'
  - shadow stays unchanged; a partial load is discarded
- The counter is held at 0 in IDLE.
- Acks:
  - an ack sets ack_pending and latches tx_byte
  - tx_start pulses for one cycle when ack_pending=1 and tx_busy=0, which clears ack_pending
  - a new ack while one is pending overwrites tx_byte and keeps a single pending ack (latest wins)

## Timing
- All outputs are registered.
- rx_valid in cycle N → src_sel, user_int, shadow and state update at N+1.
- ram_we is high for exactly cycle N+1, with ram_addr and ram_din stable in that cycle.
- err pulses at N+1.
- Ack: ack_pending is set at N+1. tx_start goes high no earlier than N+2, in the first cycle with tx_busy=0.
- rx_valid and the timeout-reaching tick in the same cycle: the byte is processed and the counter clears. No timeout occurs.
- rx_valid in the same cycle as tx_start: the new ack becomes pending and the in-flight byte is unaffected.
- rst asserted mid-command: the next cycle is IDLE with all reset values. No ram_we is issued and any partial shift contents are lost.
- ram_addr wraps naturally; any 8-bit address is legal.
- Back-to-back rx_valid on consecutive cycles is supported. There are no bubbles in LOAD.

## Structure
- Shared package `lights_pkg` holds:
  - command character constants: CMD_AUTO, CMD_RAND, CMD_STORED, CMD_USER, CMD_UPDATE, CMD_PUT, CMD_WRITE
  - ACK_OK ('!') and ACK_ERR ('?')
  - the src_sel encoding as a typedef
  - the state typedef
- Sub-module `cmd_timeout`: tick counter with clear and enable inputs and a one-cycle expire output.
- The top level muxes intensities with src_sel, using AUTO to select by USB presence.

## Test plan
- Reset, then rx 'r' → src_sel=1 at N+1. One tx_start with tx_byte=0x21. err=0.
- 'p' followed by bytes 01..09, then 'u' → user_int=72'h010203040506070809. Two '!' acks.
- After that load, 'w' then 0x7F → one cycle with ram_we=1, ram_addr=0x7F, ram_din=72'h010203040506070809. Then '!'.
- 'p' plus 3 bytes, then 64 ticks idle → err pulse, ack 0x3F, state IDLE, shadow unchanged. A following 'u' leaves user_int unchanged from its prior value.
- Byte 'x' sent with tx_busy held high for 100 cycles → no tx_start while busy. Exactly one tx_start of 0x3F after release. src_sel unchanged.
- 'w' then rst before the address byte → ram_we stays 0 and src_sel=0. The next address byte is treated as a command and gets a '?' ack.
